// File: rtl/mdu_ctrl_if.sv
// Pipeline/MDU handshake bundle for mdu_ctrl: E-stage request, MDU issue port and HI/LO read-back.
interface mdu_ctrl_if;
   logic        req_valid;
   logic [3:0]  req_op;
   logic [31:0] req_a;
   logic [31:0] req_b;
   logic        flush;
   logic        stall;
   logic        md_en;
   logic [3:0]  md_op;
   logic [31:0] md_d1;
   logic [31:0] md_d2;
   logic        md_busy;
   logic [31:0] md_out;
   logic        rd_valid;
   logic [31:0] rd_data;
   logic        err;

   modport master (
      output req_valid, req_op, req_a, req_b, flush, md_busy, md_out,
      input  stall, md_en, md_op, md_d1, md_d2, rd_valid, rd_data, err
   );

   modport slave (
      input  req_valid, req_op, req_a, req_b, flush, md_busy, md_out,
      output stall, md_en, md_op, md_d1, md_d2, rd_valid, rd_data, err
   );
endinterface

// File: rtl/mdu_ctrl.sv
// E-stage MDU sequencer: issues mult/div/acc/move-to in 0 cycles, move-from reads take 1 stall cycle.
// Stalls live requests while the MDU is busy; MDU_TIMEOUT_EN adds a sticky busy-timeout err flag.
`ifndef MULT
`define MULT  4'd0
`define MULTU 4'd1
`define DIV   4'd2
`define DIVU  4'd3
`define MTHI  4'd4
`define MTLO  4'd5
`define MFHI  4'd6
`define MFLO  4'd7
`define MADDU 4'd8
`endif

module mdu_ctrl #(
   parameter int TIMEOUT = 31
) (
   input  logic       clk,
   input  logic       rst,
   mdu_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, BUSY, READ} state_t;

   state_t state_q, state_d;
   logic   live, is_start, is_acc, is_mt, is_mf;
   logic   timeout_hit;

   assign live     = bus.req_valid & ~bus.flush;
   assign is_start = bus.req_op inside {`MULT, `MULTU, `DIV, `DIVU};
   assign is_acc   = (bus.req_op == `MADDU);
   assign is_mt    = bus.req_op inside {`MTHI, `MTLO};
   assign is_mf    = bus.req_op inside {`MFHI, `MFLO};

   assign bus.md_d1 = bus.req_a;
   assign bus.md_d2 = bus.req_b;

   always_comb begin
      state_d      = state_q;
      bus.stall    = 1'b0;
      bus.md_en    = 1'b0;
      bus.md_op    = 4'hF;
      bus.rd_valid = 1'b0;
      bus.rd_data  = 32'd0;
      if (!rst) begin
         case (state_q)
            IDLE: begin
               if (live) begin
                  if (bus.md_busy) begin
                     bus.stall = 1'b1;
                     if (is_mf) bus.md_op = bus.req_op;
                  end else if (is_start || is_acc || is_mt) begin
                     bus.md_en = 1'b1;
                     bus.md_op = bus.req_op;
                     if (is_start) state_d = BUSY;
                  end else if (is_mf) begin
                     // Present the read op now; md_out is registered, data lands next cycle.
                     bus.stall = 1'b1;
                     bus.md_op = bus.req_op;
                     state_d   = READ;
                  end
               end
            end
            BUSY: begin
               if (live) begin
                  bus.stall = 1'b1;
                  if (is_mf) bus.md_op = bus.req_op;
               end
               if (!bus.md_busy || timeout_hit) state_d = IDLE;
            end
            READ: begin
               bus.md_op = bus.req_op;
               state_d   = IDLE;
               if (!bus.flush) begin
                  bus.rd_valid = 1'b1;
                  bus.rd_data  = bus.md_out;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

`ifdef MDU_TIMEOUT_EN
   localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

   logic [7:0] cnt_q, cnt_d;
   logic       err_q, err_d;

   // Counter sits at zero outside BUSY, so it starts from zero on every BUSY entry.
   always_comb begin
      cnt_d       = (state_q == BUSY) ? cnt_q + 8'd1 : 8'd0;
      timeout_hit = (state_q == BUSY) && bus.md_busy && (cnt_d == TO_LIMIT);
      err_d       = err_q | timeout_hit;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= 8'd0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   assign bus.err = err_q;
`else
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign timeout_hit    = 1'b0;
   assign bus.err        = 1'b0;
`endif
endmodule

// File: tb/tb_mdu_ctrl.sv
// Randomized and directed bench for mdu_ctrl against a behavioural MDU and HI/LO architectural model.
module tb_mdu_ctrl;
   localparam logic [3:0] OP_MULT = 4'd0, OP_MULTU = 4'd1, OP_DIV = 4'd2, OP_DIVU = 4'd3,
                          OP_MTHI = 4'd4, OP_MTLO = 4'd5, OP_MFHI = 4'd6, OP_MFLO = 4'd7,
                          OP_MADDU = 4'd8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   bit   rst_req = 1'b1;
   always #5 clk = ~clk;

   mdu_ctrl_if bus();
   mdu_ctrl #(.TIMEOUT(31)) dut (.clk(clk), .rst(rst), .bus(bus));

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h", tag, act, exp);
      end
   endtask

   // Architectural effect of an MDU op on {HI,LO}.
   function automatic logic [63:0] exec(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] hl);
      logic signed [63:0] sa, sb;
      logic signed [31:0] a32, b32;
      sa  = {{32{a[31]}}, a};
      sb  = {{32{b[31]}}, b};
      a32 = a;
      b32 = b;
      case (op)
         OP_MULT:  return sa * sb;
         OP_MULTU: return {32'd0, a} * {32'd0, b};
         OP_DIV:   return {32'(a32 % b32), 32'(a32 / b32)};
         OP_DIVU:  return {a % b, a / b};
         OP_MTHI:  return {a, hl[31:0]};
         OP_MTLO:  return {hl[63:32], a};
         OP_MADDU: return hl + {32'd0, a} * {32'd0, b};
         default:  return hl;
      endcase
   endfunction

   // Behavioural MDU: busy for a random 1..5 cycles after a start op, registered HI/LO read port.
   logic [63:0] m_hilo     = 64'd0;
   int          m_busy_cnt = 0;
   bit          stuck_busy = 1'b0;
   assign bus.md_busy = (m_busy_cnt != 0) || stuck_busy;

   always @(posedge clk) begin
      if (rst) begin
         m_busy_cnt <= 0;
      end else begin
         if (m_busy_cnt != 0) m_busy_cnt <= m_busy_cnt - 1;
         if (bus.md_op == OP_MFHI)      bus.md_out <= m_hilo[63:32];
         else if (bus.md_op == OP_MFLO) bus.md_out <= m_hilo[31:0];
         if (bus.md_en) begin
            m_hilo <= exec(bus.md_op, bus.md_d1, bus.md_d2, m_hilo);
            if (bus.md_op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU})
               m_busy_cnt <= int'($urandom_range(1, 5));
         end
      end
   end

   // One pipeline cycle: drive after the edge, sample at the falling edge, apply cycle-wide rules.
   task automatic cyc(input logic v, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic fl);
      @(posedge clk);
      #1;
      rst           = rst_req;
      bus.req_valid = v;
      bus.req_op    = op;
      bus.req_a     = a;
      bus.req_b     = b;
      bus.flush     = fl;
      @(negedge clk);
      chk("md_d1", bus.md_d1, a);
      chk("md_d2", bus.md_d2, b);
      if (rst) begin
         chk("rst_stall", bus.stall, 0);
         chk("rst_md_en", bus.md_en, 0);
         chk("rst_md_op", bus.md_op, 4'hF);
         chk("rst_rd_valid", bus.rd_valid, 0);
      end else begin
         if (!(v && !fl)) begin
            chk("dead_stall", bus.stall, 0);
            chk("dead_md_en", bus.md_en, 0);
            chk("dead_rd_valid", bus.rd_valid, 0);
         end else if (bus.md_busy) begin
            chk("busy_stall", bus.stall, 1);
            chk("busy_md_en", bus.md_en, 0);
         end
         if (bus.md_en) chk("issue_md_op", bus.md_op, op);
      end
      if (!bus.rd_valid) chk("rd_data_zero", bus.rd_data, 0);
`ifndef MDU_TIMEOUT_EN
      chk("err_tied", bus.err, 0);
`endif
   endtask

   // A move-from with an idle MDU: exactly one stall cycle, then the value.
   task automatic read_mf(input logic [3:0] op, input logic [31:0] exp, input string tag);
      cyc(1, op, 32'd0, 32'd0, 0);
      chk({tag, "_stall1"}, bus.stall, 1);
      chk({tag, "_md_op"}, bus.md_op, op);
      chk({tag, "_early_rdv"}, bus.rd_valid, 0);
      cyc(1, op, 32'd0, 32'd0, 0);
      chk({tag, "_stall0"}, bus.stall, 0);
      chk({tag, "_rd_valid"}, bus.rd_valid, 1);
      chk({tag, "_rd_data"}, bus.rd_data, exp);
   endtask

   logic [63:0] arch;
   logic [3:0]  op;
   logic [31:0] a, b;
   int          n, waitc;
   bit          done, fl, abort;
   logic [3:0]  b2b_ops [4] = '{OP_MTHI, OP_MTLO, OP_MADDU, OP_MTHI};

   initial begin
      bus.req_valid = 0; bus.req_op = 0; bus.req_a = 0; bus.req_b = 0; bus.flush = 0;
      bus.md_out = 0;
      abort = 0;

      // Reset, with a live request present
      rst_req = 1;
      cyc(1, OP_MFLO, 32'd1, 32'd2, 0);
      cyc(1, OP_MULT, 32'd1, 32'd2, 0);
      chk("rst_rd_data", bus.rd_data, 0);
      chk("rst_err", bus.err, 0);
      rst_req = 0;

      // Flushed MULT issues nothing and leaves the FSM idle
      cyc(1, OP_MULT, 32'd9, 32'd9, 1);
      chk("flush_md_en", bus.md_en, 0);
      chk("flush_stall", bus.stall, 0);
      cyc(1, OP_MTLO, 32'h12345678, 32'd0, 0);
      chk("mtlo_stall", bus.stall, 0);
      chk("mtlo_md_en", bus.md_en, 1);
      read_mf(OP_MFLO, 32'h12345678, "mflo_a");

      // Back-to-back move-to / acc
      foreach (b2b_ops[k]) begin
         cyc(1, b2b_ops[k], 32'(k + 1), 32'd3, 0);
         chk("b2b_stall", bus.stall, 0);
         chk("b2b_md_en", bus.md_en, 1);
      end

      // MULT 3 * -2, MFLO held through the busy window
      cyc(1, OP_MULT, 32'd3, 32'hFFFFFFFE, 0);
      chk("mult_md_en", bus.md_en, 1);
      chk("mult_stall", bus.stall, 0);
      n = 0;
      do begin
         cyc(1, OP_MFLO, 32'd0, 32'd0, 0);
         n++;
      end while (bus.stall && n < 20);
      chk("mult_rd_valid", bus.rd_valid, 1);
      chk("mult_rd_data", bus.rd_data, 32'hFFFFFFFA);
      cyc(0, 4'd0, 32'd0, 32'd0, 0);
      chk("mult_rd_once", bus.rd_valid, 0);

      // DIV 7/2 then MTHI 5 waits for the MDU
      cyc(1, OP_DIV, 32'd7, 32'd2, 0);
      chk("div_md_en", bus.md_en, 1);
      n = 0;
      do begin
         cyc(1, OP_MTHI, 32'd5, 32'd0, 0);
         n++;
         if (bus.stall) chk("mthi_wait_en", bus.md_en, 0);
      end while (bus.stall && n < 20);
      chk("mthi_md_en", bus.md_en, 1);
      chk("mthi_md_op", bus.md_op, OP_MTHI);
      chk("mthi_md_d1", bus.md_d1, 32'd5);
      chk("mthi_after_busy", bus.md_busy, 0);
      read_mf(OP_MFLO, 32'd3, "div_lo");
      read_mf(OP_MFHI, 32'd5, "mthi_hi");

      // Reset in the middle of a MULTU
      cyc(1, OP_MULTU, 32'd100, 32'd200, 0);
      chk("multu_md_en", bus.md_en, 1);
      cyc(0, 4'd0, 32'd0, 32'd0, 0);
      rst_req = 1;
      cyc(1, OP_MFHI, 32'd0, 32'd0, 0);
      rst_req = 0;
      cyc(0, 4'd0, 32'd0, 32'd0, 0);
      chk("post_rst_stall", bus.stall, 0);
      chk("post_rst_md_en", bus.md_en, 0);
      cyc(1, OP_MTLO, 32'hCAFE0001, 32'd0, 0);
      chk("post_rst_issue", bus.md_en, 1);
      chk("post_rst_nostall", bus.stall, 0);

`ifdef MDU_TIMEOUT_EN
      // MDU stuck busy: err after 31 BUSY cycles, FSM back in IDLE, sticky until reset
      stuck_busy = 1;
      cyc(1, OP_MULT, 32'd1, 32'd1, 0);
      chk("to_issue", bus.md_en, 1);
      n = 0;
      do begin
         cyc(0, 4'd0, 32'd0, 32'd0, 0);
         n++;
      end while (!bus.err && n < 60);
      chk("to_cycles", n, 32);
      cyc(1, OP_MTLO, 32'd7, 32'd0, 0);
      chk("to_busy_stall", bus.stall, 1);
      stuck_busy = 0;
      cyc(1, OP_MTLO, 32'd7, 32'd0, 0);
      chk("to_idle_issue", bus.md_en, 1);
      chk("to_err_sticky", bus.err, 1);
      rst_req = 1;
      cyc(0, 4'd0, 32'd0, 32'd0, 0);
      rst_req = 0;
      cyc(0, 4'd0, 32'd0, 32'd0, 0);
      chk("to_err_cleared", bus.err, 0);
`endif

      // Random program against the architectural HI/LO model
      arch = m_hilo;
      for (int i = 0; i < 300 && !abort; i++) begin
         op = 4'($urandom_range(0, 8));
         a  = $urandom;
         b  = (op == OP_DIV || op == OP_DIVU) ? 32'($urandom_range(1, 1000)) : $urandom;
         if ($urandom_range(0, 4) == 0) cyc(0, 4'd0, $urandom, $urandom, 0);
         waitc = 0;
         done  = 0;
         while (!done) begin
            fl = ($urandom_range(0, 11) == 0);
            cyc(1, op, a, b, fl);
            if (fl) begin
               done = 1;
            end else if (!bus.stall) begin
               if (op == OP_MFHI || op == OP_MFLO) begin
                  chk("rnd_rd_valid", bus.rd_valid, 1);
                  chk("rnd_rd_data", bus.rd_data, (op == OP_MFHI) ? arch[63:32] : arch[31:0]);
               end else begin
                  chk("rnd_md_en", bus.md_en, 1);
                  arch = exec(op, a, b, arch);
               end
               done = 1;
            end else begin
               waitc++;
               if (waitc > 40) begin
                  chk("rnd_stall_bound", bus.stall, 0);
                  abort = 1;
                  done  = 1;
               end
            end
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
